// File: rtl/rst_sequencer_pkg.sv
// Shared cause codes, FSM state encodings and a constant helper for the reset sequencer.
// Pure declarations; no timing or flow control of its own.
package rst_seq_defs;

  localparam logic [1:0] RST_CAUSE_POR = 2'd0;
  localparam logic [1:0] RST_CAUSE_SW  = 2'd1;
  localparam logic [1:0] RST_CAUSE_WDT = 2'd2;
  localparam logic [1:0] RST_CAUSE_DBG = 2'd3;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Clearable saturating up-counter; tc is high while the count equals the compare value.
// Count updates one edge after clr/enable; it stops at the compare value and never wraps.
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt < tc_val) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/rst_sequencer.sv
// Merges POR/SW/WDT/DBG requests into a timed hold, then releases domains in order with a gap.
// Optional RST_SEQ_HANDSHAKE_EN: each next release also waits for domain_ready of the previous domain.
module rst_sequencer
  import rst_seq_defs::*;
#(
  parameter int N_DOMAINS   = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_sw,
  input  logic                 req_wdt,
  input  logic                 req_dbg,
  output logic [N_DOMAINS-1:0] domain_rst_n,
  output logic                 busy,
  output logic [1:0]           cause
`ifdef RST_SEQ_HANDSHAKE_EN
  ,
  input  logic [N_DOMAINS-1:0] domain_ready
`endif
);

`ifdef RST_SEQ_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int IDX_W = $clog2(N_DOMAINS + 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOMAINS - 1);
  localparam logic [IDX_W-1:0] IDX_N    = IDX_W'(N_DOMAINS);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DOMAINS-1:0] mask_d;
  logic                 busy_d;
  logic [1:0]           cause_d;

  logic             req_any;
  logic [1:0]       req_cause;
  logic             tmr_clr;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_cmp;
  logic             prev_ok;
  logic             last_ok;
  logic             hold_done;
  logic             gap_done;

  assign req_any   = req_sw | req_wdt | req_dbg;
  assign req_cause = req_dbg ? RST_CAUSE_DBG :
                     req_wdt ? RST_CAUSE_WDT : RST_CAUSE_SW;

  // One timer serves both phases; every phase change also clears it.
  assign tmr_cmp = (state_q == ST_ASSERT) ? HOLD_TC : GAP_TC;

  rst_seq_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .tc_val (tmr_cmp),
    .tc     (tmr_tc)
  );

`ifdef RST_SEQ_HANDSHAKE_EN
  // Ready from a domain still held in reset is masked off.
  always_comb begin
    prev_ok = 1'b0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      if (idx_q == IDX_W'(i + 1)) prev_ok = domain_ready[i] & domain_rst_n[i];
    end
  end
  assign last_ok = domain_ready[N_DOMAINS-1] & domain_rst_n[N_DOMAINS-1];
`else
  assign prev_ok = 1'b1;
  assign last_ok = 1'b0;
`endif

  assign hold_done = (state_q == ST_ASSERT) && tmr_tc;
  assign gap_done  = (state_q == ST_STAGGER) && tmr_tc && prev_ok && (idx_q != IDX_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ASSERT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // idx counts released domains; idx == N only occurs while waiting for the last ready.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_clr = 1'b0;
    if (req_any) begin
      state_d = ST_ASSERT;
      idx_d   = '0;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_done) begin
            tmr_clr = 1'b1;
            idx_d   = IDX_W'(1);
            state_d = (N_DOMAINS == 1 && !HS) ? ST_RUN : ST_STAGGER;
          end
        end
        ST_STAGGER: begin
          if (gap_done) begin
            tmr_clr = 1'b1;
            idx_d   = idx_q + IDX_W'(1);
            if (!HS && idx_q == LAST_IDX) state_d = ST_RUN;
          end else if (HS && idx_q == IDX_N && last_ok) begin
            state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mask_d  = domain_rst_n;
    cause_d = cause;
    if (req_any) begin
      mask_d  = '0;
      cause_d = req_cause;
    end else if (hold_done) begin
      mask_d[0] = 1'b1;
    end else if (gap_done) begin
      for (int i = 0; i < N_DOMAINS; i++) begin
        if (idx_q == IDX_W'(i)) mask_d[i] = 1'b1;
      end
    end
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      domain_rst_n <= '0;
      busy         <= 1'b1;
      cause        <= RST_CAUSE_POR;
    end else begin
      domain_rst_n <= mask_d;
      busy         <= busy_d;
      cause        <= cause_d;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with hand-derived release schedules (N=3, HOLD=8, GAP=4).
module tb_rst_sequencer;

  localparam int N    = 3;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
`ifdef RST_SEQ_HANDSHAKE_EN
  localparam int BUSY_END = HOLD + (N - 1) * GAP + 1;
`else
  localparam int BUSY_END = HOLD + (N - 1) * GAP;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_sw = 1'b0;
  logic         req_wdt = 1'b0;
  logic         req_dbg = 1'b0;
  logic [N-1:0] domain_rst_n;
  logic         busy;
  logic [1:0]   cause;

  int n_checks = 0;
  int n_fail = 0;

`ifdef RST_SEQ_HANDSHAKE_EN
  logic         ready_auto = 1'b1;
  logic [N-1:0] ready_man = '0;
  logic [N-1:0] domain_ready;
  assign domain_ready = ready_auto ? domain_rst_n : ready_man;
`endif

  rst_sequencer #(.N_DOMAINS(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_sw       (req_sw),
    .req_wdt      (req_wdt),
    .req_dbg      (req_dbg),
    .domain_rst_n (domain_rst_n),
    .busy         (busy),
    .cause        (cause)
`ifdef RST_SEQ_HANDSHAKE_EN
    ,
    .domain_ready (domain_ready)
`endif
  );

  always #5 clk = ~clk;

  // Domain i is expected released from relative edge HOLD + i*GAP onward.
  function automatic logic [N-1:0] exp_mask(input int k);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = (k >= HOLD + i * GAP);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (domain_rst_n !== 3'b000) begin
      n_fail++; $display("FAIL reset_mask got=%b exp=000", domain_rst_n);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy got=%b exp=1", busy);
    end
    n_checks++;
    if (cause !== 2'd0) begin
      n_fail++; $display("FAIL reset_cause got=%0d exp=0", cause);
    end
  endtask

  task automatic test_por();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++;
      if (domain_rst_n !== exp_mask(k) || busy !== (k < BUSY_END)) begin
        n_fail++;
        $display("FAIL por_seq edge=%0d got=%b/%b exp=%b/%b", k, domain_rst_n, busy,
                 exp_mask(k), (k < BUSY_END));
      end
    end
    n_checks++;
    if (cause !== 2'd0) begin
      n_fail++; $display("FAIL por_cause got=%0d exp=0", cause);
    end
  endtask

  task automatic test_sw();
    req_sw = 1'b1;
    tick();
    req_sw = 1'b0;
    n_checks++;
    if (cause !== 2'd1) begin
      n_fail++; $display("FAIL sw_cause got=%0d exp=1", cause);
    end
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (domain_rst_n !== exp_mask(k) || busy !== (k < BUSY_END)) begin
        n_fail++;
        $display("FAIL sw_seq edge=%0d got=%b/%b exp=%b/%b", k, domain_rst_n, busy,
                 exp_mask(k), (k < BUSY_END));
      end
    end
  endtask

  task automatic test_dbg();
    req_dbg = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      n_checks++;
      if (domain_rst_n !== 3'b000 || busy !== 1'b1) begin
        n_fail++; $display("FAIL dbg_hold cyc=%0d got=%b/%b exp=000/1", j, domain_rst_n, busy);
      end
    end
    req_dbg = 1'b0;
    n_checks++;
    if (cause !== 2'd3) begin
      n_fail++; $display("FAIL dbg_cause got=%0d exp=3", cause);
    end
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_checks++;
      if (domain_rst_n !== exp_mask(k) || busy !== (k < BUSY_END)) begin
        n_fail++;
        $display("FAIL dbg_seq edge=%0d got=%b/%b exp=%b/%b", k, domain_rst_n, busy,
                 exp_mask(k), (k < BUSY_END));
      end
    end
  endtask

  task automatic test_simultaneous();
    req_sw = 1'b1;
    req_wdt = 1'b1;
    tick();
    req_sw = 1'b0;
    req_wdt = 1'b0;
    n_checks++;
    if (cause !== 2'd2) begin
      n_fail++; $display("FAIL simul_cause got=%0d exp=2", cause);
    end
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (domain_rst_n !== exp_mask(k) || busy !== (k < BUSY_END)) begin
        n_fail++;
        $display("FAIL simul_seq edge=%0d got=%b/%b exp=%b/%b", k, domain_rst_n, busy,
                 exp_mask(k), (k < BUSY_END));
      end
    end
  endtask

  task automatic test_back_to_back();
    req_sw = 1'b1;
    tick();
    req_sw = 1'b0;
    for (int j = 1; j <= 4; j++) tick();
    req_sw = 1'b1;
    tick();
    req_sw = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (domain_rst_n !== exp_mask(k) || busy !== (k < BUSY_END)) begin
        n_fail++;
        $display("FAIL b2b_seq edge=%0d got=%b/%b exp=%b/%b", k, domain_rst_n, busy,
                 exp_mask(k), (k < BUSY_END));
      end
    end
  endtask

  task automatic test_async_reset();
    req_sw = 1'b1;
    tick();
    req_sw = 1'b0;
    for (int j = 1; j <= 10; j++) tick();
    n_checks++;
    if (domain_rst_n !== 3'b001) begin
      n_fail++; $display("FAIL async_pre got=%b exp=001", domain_rst_n);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (domain_rst_n !== 3'b000 || busy !== 1'b1 || cause !== 2'd0) begin
      n_fail++;
      $display("FAIL async_rst got=%b/%b/%0d exp=000/1/0", domain_rst_n, busy, cause);
    end
    tick();
  endtask

  task automatic test_mid_stagger();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) tick();
    n_checks++;
    if (domain_rst_n !== 3'b011) begin
      n_fail++; $display("FAIL mid_pre got=%b exp=011", domain_rst_n);
    end
    req_wdt = 1'b1;
    tick();
    req_wdt = 1'b0;
    n_checks++;
    if (domain_rst_n !== 3'b000 || busy !== 1'b1 || cause !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_restart got=%b/%b/%0d exp=000/1/2", domain_rst_n, busy, cause);
    end
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_checks++;
      if (domain_rst_n !== exp_mask(k) || busy !== (k < BUSY_END)) begin
        n_fail++;
        $display("FAIL mid_seq edge=%0d got=%b/%b exp=%b/%b", k, domain_rst_n, busy,
                 exp_mask(k), (k < BUSY_END));
      end
    end
  endtask

`ifdef RST_SEQ_HANDSHAKE_EN
  task automatic test_handshake();
    rst_n = 1'b0;
    #1;
    ready_auto = 1'b0;
    ready_man = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      tick();
      if (k >= 8) begin
        n_checks++;
        if (domain_rst_n !== 3'b001 || busy !== 1'b1) begin
          n_fail++; $display("FAIL hs_wait edge=%0d got=%b/%b exp=001/1", k, domain_rst_n, busy);
        end
      end
    end
    ready_man = 3'b001;
    tick();
    n_checks++;
    if (domain_rst_n !== 3'b011) begin
      n_fail++; $display("FAIL hs_rel1 edge=30 got=%b exp=011", domain_rst_n);
    end
    ready_man = 3'b011;
    for (int k = 31; k <= 33; k++) tick();
    n_checks++;
    if (domain_rst_n !== 3'b011) begin
      n_fail++; $display("FAIL hs_gap edge=33 got=%b exp=011", domain_rst_n);
    end
    tick();
    n_checks++;
    if (domain_rst_n !== 3'b111 || busy !== 1'b1) begin
      n_fail++; $display("FAIL hs_rel2 edge=34 got=%b/%b exp=111/1", domain_rst_n, busy);
    end
    ready_man = 3'b111;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL hs_run edge=35 got=%b exp=0", busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_por();
    test_sw();
    test_dbg();
    test_simultaneous();
    test_back_to_back();
    test_async_reset();
    test_mid_stagger();
`ifdef RST_SEQ_HANDSHAKE_EN
    test_handshake();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Reset controller sitting between the FPGA power-on reset generator and the SoC reset domains.
- Merges reset requests into one timed assert phase, then releases N reset domains in a fixed order with a programmable gap between releases.
- Request sources: power-on, software, watchdog, and the debug module's ndmreset.
- Records the cause of the most recent reset for firmware to read.

Parameters:
- N_DOMAINS, 3, number of sequenced reset domains; domain 0 is released first. Range 1..8.
- HOLD_CYCLES, 8, minimum number of clk edges for which all domains stay asserted. Minimum 2.
- GAP_CYCLES, 4, clk edges between successive domain releases. Minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset (power-on, from the FPGA reset generator).
- req_sw  in  1  software reset request; single-cycle pulse.
- req_wdt  in  1  watchdog reset request; single-cycle pulse.
- req_dbg  in  1  debug ndmreset; level, held for as long as the debugger requests reset.
- domain_rst_n  out  N_DOMAINS  per-domain active-low reset; registered outputs.
- busy  out  1  high while any domain is still asserted.
- cause  out  2  last reset cause: 0 POR, 1 SW, 2 WDT, 3 DBG.
- domain_ready  in  N_DOMAINS  only present with RST_SEQ_HANDSHAKE_EN.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n. All request inputs are already synchronous to clk.
- Reset values: domain_rst_n = all 0, busy = 1, cause = 0 (POR), state = ASSERT, counter = 0, domain index = 0.
- Edge numbering: edge 1 is the first clk posedge with rst_n high. A request sampled at edge e restarts the sequence with e acting as edge 0.
- State ASSERT:
  - All domain_rst_n are 0. Counter increments each edge.
  - Moves to STAGGER at the edge where counter reaches HOLD_CYCLES-1 and no request is active.
  - At that same edge domain_rst_n[0] goes to 1, so domain 0 rises at edge HOLD_CYCLES.
- State STAGGER:
  - Counter restarts at 0. Every GAP_CYCLES edges the next domain is released.
  - Domain i rises at edge HOLD_CYCLES + i*GAP_CYCLES.
  - At the edge releasing domain N_DOMAINS-1 the state goes to RUN and busy falls.
  - With N_DOMAINS=1, STAGGER is skipped: ASSERT goes directly to RUN.
- State RUN: all domains released, busy = 0. Idle until a request arrives.
- Any request (req_sw, req_wdt or req_dbg high) sampled in any state:
  - Next state is ASSERT, counter = 0, domain index = 0.
  - All domain_rst_n go to 0 and busy goes to 1 at that edge.
  - Cause is updated at that edge.
- req_dbg held high keeps the counter at 0. Domain 0 rises HOLD_CYCLES edges after the last edge on which req_dbg was sampled high.
- Simultaneous requests: cause priority is DBG > WDT > SW. A single transition is taken.
- Request during STAGGER: domains already released are re-asserted immediately. There is no partial release.
- Request in ASSERT: hold counter restarts, so back-to-back pulses extend the hold.
- Counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). The counter never wraps; it saturates at its terminal count.
- domain_rst_n bits are monotonic within one sequence: once a bit is 1 it returns to 0 only on a new request or rst_n.
- rst_n asserted mid-sequence: all outputs return asynchronously to their reset values and cause = POR.

Optional Feature:
- Macro: RST_SEQ_HANDSHAKE_EN.
- With the macro defined:
  - The domain_ready port exists.
  - In STAGGER, domain i+1 is released only once both GAP_CYCLES have elapsed since domain i was released and domain_ready[i] has been sampled high.
  - The gap counter saturates while waiting.
  - The transition to RUN additionally requires domain_ready[N_DOMAINS-1].
  - domain_ready of a domain that is still in reset is ignored.
- Without the macro: no domain_ready port; the sequence is purely timed as described above.

Decomposition:
- Shared header/package rst_seq_defs holds:
  - cause codes RST_CAUSE_POR/SW/WDT/DBG (2 bits);
  - state encodings ASSERT/STAGGER/RUN (2 bits).
- One sub-module: rst_seq_timer. It is a clear-able saturating up-counter with terminal-count compare. It is reused for both the hold and gap phases, with its compare value muxed from HOLD_CYCLES-1 or GAP_CYCLES-1.
- The FSM and domain mask stay in rst_sequencer.

Test Plan:
- POR, defaults (N=3, HOLD=8, GAP=4): deassert rst_n → domain_rst_n rises 001 at edge 8, 011 at edge 12, 111 at edge 16; busy falls at edge 16; cause = 0.
- RUN, req_sw pulse at edge e → domain_rst_n = 000 and busy = 1 after edge e; re-release at e+8, e+12, e+16; cause = 1.
- req_dbg high for 20 edges → domains held at 000 throughout; domain 0 rises 8 edges after req_dbg falls; cause = 3.
- req_sw and req_wdt in the same cycle → cause = 2; exactly one sequence runs.
- req_wdt at edge 13 of the POR sequence (domain_rst_n = 011) → 000 next edge; full sequence restarts from e = 13.
- Handshake build: domain_ready[0] held low → domain_rst_n stays at 001 indefinitely; raising domain_ready[0] at edge 30 → domain 1 releases at edge 30 or later; GAP is already satisfied.
